// File: rtl/kyber_pmul_host_seq.sv
// Host-side sequencer for a single-PE Kyber polynomial multiplier: stages A and B, drives the
// core through FNTT(A), FNTT(B), PWM2, INTT, then reorders and streams the product out.
module kyber_pmul_host_seq #(
    parameter int N   = 256,
    parameter int W   = 12,
    parameter int GAP = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         busy,
    output logic         op_done,
    output logic         load_a_f,
    output logic         load_b_f,
    output logic         read_a,
    output logic         start_ab,
    output logic         start_fntt,
    output logic         start_pwm2,
    output logic         start_intt,
    output logic [W-1:0] core_din,
    input  logic [W-1:0] core_dout,
    input  logic         core_done
);
    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_N       = CW'(N);
    localparam logic [CW-1:0] CNT_LAST    = CW'(N - 1);
    localparam logic [CW-1:0] CNT_GAPLAST = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_WAIT    = CW'(GAP + 1);
    localparam logic [CW-1:0] CNT_RDLAST  = CW'(GAP + N);
    localparam logic [AW-1:0] WAIT_LO     = AW'(GAP + 1);

    typedef enum logic [3:0] {
        IDLE, FILL_A, LOAD_A, GAP_A, FILL_B, LOAD_B, GAP_B,
        FNTT_A, FNTT_B, PWM, INTT, READ, DRAIN
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           s_ready_reg;
    logic [W-1:0]   buf_mem [N];
    logic [W-1:0]   rd_data_reg;
    logic [AW-1:0]  rd_addr, wr_addr, cap_idx;
    logic [W-1:0]   wr_data;
    logic           wr_en;
    logic           s_xfer;

    assign s_ready = s_ready_reg;
    assign busy    = (state_reg != IDLE);
    assign s_xfer  = s_valid && s_ready_reg;
    // Capture index j maps to core order 0,N/2,1,N/2+1,...: a one-bit rotate of j.
    assign cap_idx = cnt_reg[AW-1:0] - WAIT_LO;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            s_ready_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            s_ready_reg <= (state_next == IDLE) || (state_next == FILL_A) || (state_next == FILL_B);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            buf_mem[wr_addr] <= wr_data;
        rd_data_reg <= buf_mem[rd_addr];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_en      = 1'b0;
        wr_addr    = cnt_reg[AW-1:0];
        wr_data    = s_data;
        rd_addr    = cnt_reg[AW-1:0];
        m_valid    = 1'b0;
        m_data     = '0;
        op_done    = 1'b0;
        load_a_f   = 1'b0;
        load_b_f   = 1'b0;
        read_a     = 1'b0;
        start_ab   = 1'b0;
        start_fntt = 1'b0;
        start_pwm2 = 1'b0;
        start_intt = 1'b0;
        core_din   = '0;
        case (state_reg)
            IDLE, FILL_A, FILL_B: begin
                if (s_xfer) begin
                    wr_en = 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_next = (state_reg == FILL_B) ? LOAD_B : LOAD_A;
                        cnt_next   = '0;
                    end else begin
                        state_next = (state_reg == FILL_B) ? FILL_B : FILL_A;
                        cnt_next   = cnt_reg + CW'(1);
                    end
                end
            end
            LOAD_A, LOAD_B: begin
                // Read data trails the address by one cycle, so the burst occupies cycles 1..N.
                load_a_f = (state_reg == LOAD_A) && (cnt_reg == '0);
                load_b_f = (state_reg == LOAD_B) && (cnt_reg == '0);
                if (cnt_reg != '0)
                    core_din = rd_data_reg;
                if (cnt_reg == CNT_N) begin
                    state_next = (state_reg == LOAD_A) ? GAP_A : GAP_B;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            GAP_A, GAP_B: begin
                if (cnt_reg == CNT_GAPLAST) begin
                    state_next = (state_reg == GAP_A) ? FILL_B : FNTT_A;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            FNTT_A, FNTT_B, PWM, INTT: begin
                if (cnt_reg == '0) begin
                    start_fntt = (state_reg == FNTT_A) || (state_reg == FNTT_B);
                    start_ab   = (state_reg == FNTT_B);
                    start_pwm2 = (state_reg == PWM);
                    start_intt = (state_reg == INTT);
                end
                // core_done may still be high from the previous operation right after a start.
                if (cnt_reg < CNT_WAIT) begin
                    cnt_next = cnt_reg + CW'(1);
                end else if (core_done) begin
                    cnt_next = '0;
                    case (state_reg)
                        FNTT_A:  state_next = FNTT_B;
                        FNTT_B:  state_next = PWM;
                        PWM:     state_next = INTT;
                        default: state_next = READ;
                    endcase
                end
            end
            READ: begin
                read_a = (cnt_reg == '0);
                if (cnt_reg >= CNT_WAIT) begin
                    wr_en   = 1'b1;
                    wr_addr = {cap_idx[0], cap_idx[AW-1:1]};
                    wr_data = core_dout;
                end
                if (cnt_reg == CNT_RDLAST) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                    rd_addr    = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_data  = rd_data_reg;
                if (m_ready) begin
                    rd_addr = cnt_reg[AW-1:0] + AW'(1);
                    if (cnt_reg == CNT_LAST) begin
                        op_done    = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_kyber_pmul_host_seq.sv
// Bench for kyber_pmul_host_seq: behavioural core model (negacyclic product mod 3329) plus a
// scoreboard queue of expected output coefficients.
module tb_kyber_pmul_host_seq;
    localparam int N = 256, W = 12, GAP = 2, Q = 3329, LAT = 7, BUDGET = 8000;

    logic clk = 1'b0, reset = 1'b1;
    logic s_valid = 1'b0, m_ready = 1'b0;
    logic [W-1:0] s_data = '0;
    logic s_ready, m_valid, busy, op_done;
    logic [W-1:0] m_data, core_din, core_dout;
    logic load_a_f, load_b_f, read_a, start_ab, start_fntt, start_pwm2, start_intt, core_done;
    logic [34:0] all_outs;

    kyber_pmul_host_seq #(.N(N), .W(W), .GAP(GAP)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .op_done(op_done),
        .load_a_f(load_a_f), .load_b_f(load_b_f), .read_a(read_a),
        .start_ab(start_ab), .start_fntt(start_fntt), .start_pwm2(start_pwm2),
        .start_intt(start_intt), .core_din(core_din), .core_dout(core_dout),
        .core_done(core_done)
    );

    always #5 clk = ~clk;

    assign all_outs = {s_ready, m_valid, m_data, busy, op_done, load_a_f, load_b_f, read_a,
                       start_ab, start_fntt, start_pwm2, start_intt, core_din};

    int checks = 0, errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [11:0] nmul(input logic [11:0] a [N], input logic [11:0] b [N],
                                          input int k);
        int acc, p;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            if (i <= k) p = (int'(a[i]) * int'(b[k - i])) % Q;
            else        p = Q - (int'(a[i]) * int'(b[k - i + N])) % Q;
            acc = (acc + p) % Q;
        end
        return 12'(acc);
    endfunction

    // ---------------- core model ----------------
    logic [11:0] ma [N];
    logic [11:0] mb [N];
    int lcnt, rcnt, dcnt, proto_err = 0;
    logic lsel, fa, fb, pw, ok;
    bit stuck = 0;
    logic la_s = 0, lb_s = 0, rd_s = 0, sf_s = 0, ab_s = 0, sp_s = 0, si_s = 0;
    logic [W-1:0] din_s = '0;

    assign core_done = stuck ? 1'b1 : (dcnt == 0);

    function automatic int next_r();
        if (rd_s) return 1;
        if (rcnt != 0 && rcnt < GAP + N) return rcnt + 1;
        return 0;
    endfunction

    function automatic logic [11:0] dout_for(input int r);
        int j, k;
        if (r >= GAP + 1 && r <= GAP + N) begin
            j = r - GAP - 1;
            k = (j >> 1) + ((j % 2 == 1) ? N / 2 : 0);
            return ok ? nmul(ma, mb, k) : 12'hFFF;
        end
        return 12'h000;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lcnt <= 0; rcnt <= 0; dcnt <= 0; lsel <= 1'b0;
            fa <= 1'b0; fb <= 1'b0; pw <= 1'b0; ok <= 1'b0; core_dout <= '0;
        end else begin
            if (la_s || lb_s) begin
                if (lcnt != 0) proto_err <= proto_err + 1;
                lcnt <= 1;
                lsel <= lb_s;
                if (lb_s) fb <= 1'b0; else fa <= 1'b0;
                pw <= 1'b0;
                ok <= 1'b0;
            end else if (lcnt != 0) begin
                if (lsel) mb[lcnt - 1] <= din_s; else ma[lcnt - 1] <= din_s;
                lcnt <= (lcnt == N) ? 0 : lcnt + 1;
            end
            if (sf_s || sp_s || si_s || rd_s) begin
                if (!stuck && dcnt != 0) proto_err <= proto_err + 1;
                dcnt <= LAT;
            end else if (dcnt != 0) begin
                dcnt <= dcnt - 1;
            end
            if (sf_s && !ab_s) fa <= 1'b1;
            if (sf_s && ab_s)  fb <= 1'b1;
            if (sp_s)          pw <= fa && fb;
            if (si_s)          ok <= pw;
            rcnt      <= next_r();
            core_dout <= dout_for(next_r());
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [11:0] exp_q [$];
    int cyc = 0, out_idx = 0, fntt_idx = 0, done_cnt = 0, last_op = -1;
    bit intt_seen = 0, hold_pend = 0;
    logic [W-1:0] hold_data = '0;

    always @(negedge clk) begin
        logic [11:0] e;
        la_s = load_a_f; lb_s = load_b_f; rd_s = read_a; sf_s = start_fntt;
        ab_s = start_ab; sp_s = start_pwm2; si_s = start_intt; din_s = core_din;
        if (reset) begin
            hold_pend = 0;
        end else begin
            cyc++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_output actual=index %0d required=no output", out_idx);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("m_data[%0d]", out_idx), m_data, e);
                    check("op_done_at_accept", op_done, out_idx == N - 1);
                end
                if (op_done) done_cnt++;
                out_idx++;
            end else begin
                check("op_done_idle", op_done, 0);
            end
            if (hold_pend) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, hold_data);
            end
            hold_pend = m_valid && !m_ready;
            hold_data = m_data;
            if (start_fntt) begin
                check("start_ab_sel", start_ab, fntt_idx == 1);
                fntt_idx++;
            end else begin
                check("start_ab_alone", start_ab, 0);
            end
            if (start_intt) intt_seen = 1;
            if (load_a_f || load_b_f) check("core_din_pulse", core_din, 0);
            if (stuck && (start_fntt || start_pwm2 || start_intt || read_a)) begin
                if (last_op >= 0) check("stale_done_gap", cyc - last_op, GAP + 2);
                last_op = cyc;
            end
        end
    end

    // ---------------- vectors and drivers ----------------
    typedef struct {
        string name;
        int    amode;     // 0 zero, 1 x^0, 2 random
        int    bmode;
        int    vpct;
        int    rpct;
        bit    stuck;
        int    exp_outs;
        int    exp_dones;
    } vec_t;

    vec_t vecs [5];
    logic [11:0] ina [N];
    logic [11:0] inb [N];

    task automatic drive(input vec_t v, input int mode, output bit reached);
        int sent, stop_i;
        for (int k = 0; k < N; k++) begin
            ina[k] = (v.amode == 0) ? 12'd0 : (v.amode == 1) ? ((k == 0) ? 12'd1 : 12'd0)
                                                             : 12'($urandom_range(Q - 1));
            inb[k] = (v.bmode == 0) ? 12'd0 : (v.bmode == 1) ? ((k == 0) ? 12'd1 : 12'd0)
                                                             : 12'($urandom_range(Q - 1));
        end
        for (int k = 0; k < N; k++) begin
            if (v.amode == 1)                      exp_q.push_back(inb[k]);
            else if (v.bmode == 1)                 exp_q.push_back(ina[k]);
            else if (v.amode == 0 || v.bmode == 0) exp_q.push_back(12'd0);
            else                                   exp_q.push_back(nmul(ina, inb, k));
        end
        out_idx = 0; fntt_idx = 0; done_cnt = 0; last_op = -1; intt_seen = 0;
        stuck = v.stuck;
        sent = 0;
        reached = 0;
        for (int c = 0; c < BUDGET && !reached; c++) begin
            @(posedge clk); #1;
            s_valid = (sent < 2 * N) && ($urandom_range(99) < v.vpct);
            s_data  = (sent < N) ? ina[sent] : (sent < 2 * N) ? inb[sent - N] : 12'd0;
            m_ready = ($urandom_range(99) < v.rpct);
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            stop_i = (mode == 0) ? done_cnt : (mode == 1) ? int'(intt_seen) : int'(out_idx >= 40);
            reached = (stop_i != 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit reached;
        int pbase;
        pbase = proto_err;
        drive(v, 0, reached);
        @(posedge clk); #1;
        s_valid = 0; m_ready = 0;
        @(negedge clk);
        check({v.name, "_done_count"}, done_cnt, v.exp_dones);
        check({v.name, "_out_count"}, out_idx, v.exp_outs);
        check({v.name, "_queue_left"}, exp_q.size(), 0);
        check({v.name, "_busy_after"}, busy, 0);
        check({v.name, "_core_protocol"}, proto_err - pbase, 0);
        $display("vector %s outputs=%0d op_done=%0d cycle=%0d", v.name, out_idx, done_cnt, cyc);
        exp_q.delete();
        stuck = 0;
    endtask

    task automatic reset_mid(input vec_t v, input int mode, input string nm);
        bit reached;
        drive(v, mode, reached);
        if (mode == 1) repeat (3) @(posedge clk);
        check({nm, "_reached"}, reached, 1);
        @(posedge clk); #1;
        reset = 1; s_valid = 0; m_ready = 0;
        @(negedge clk);
        check({nm, "_outs"}, all_outs, 0);
        $display("reset %s asserted at cycle %0d outputs=%0d", nm, cyc, out_idx);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        exp_q.delete();
        stuck = 0;
    endtask

    initial begin
        vecs[0] = '{"x0_times_zero",  1, 0, 100, 100, 1'b0, N, 1};
        vecs[1] = '{"x0_times_b",     1, 2, 100, 100, 1'b0, N, 1};
        vecs[2] = '{"rand_valid50",   2, 2,  50, 100, 1'b0, N, 1};
        vecs[3] = '{"rand_backpres",  2, 2,  60,  40, 1'b0, N, 1};
        vecs[4] = '{"stuck_done",     2, 1,  70,  60, 1'b1, N, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", all_outs, 0);
        @(posedge clk); #1 reset = 0;
        repeat (2) @(negedge clk);
        check("idle_ready", s_ready, 1);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        reset_mid(vecs[2], 1, "rst_mid_intt");
        reset_mid(vecs[3], 2, "rst_mid_drain");
        run_vec(vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
